// File: rtl/window_filter_pkg.sv
// ---------------------------------------------------------------------------
// window_filter_pkg
// Shared types and helpers for the 3x3 window filter.
//   mode_e      : kernel selection, captured once per frame
//   state_e     : window shifter states
//   LATENCY     : col_i -> pix_o delay of the complete filter
//   clamp_range : saturate an integer into [0, hi]
// ---------------------------------------------------------------------------
package window_filter_pkg;

    localparam int LATENCY = 4;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_GAUSS   = 2'd1,
        MODE_SOBEL   = 2'd2,
        MODE_SHARPEN = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic int clamp_range(input int value, input int hi);
        if (value < 0) begin
            return 0;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/window_filter3x3_kernel.sv
// ---------------------------------------------------------------------------
// filter_kernel3x3
// Two-stage arithmetic pipeline applying the selected 3x3 kernel to a window.
//   clk, rst            : clock, synchronous active-high reset
//   i_col_l/m/r [2:0]   : window columns left/middle/right; [2] top, [0] bottom
//   i_mode              : kernel select (already frame-stable)
//   i_valid             : window holds a real centre pixel
//   o_pix               : filtered pixel, 0 whenever o_valid is low
//   o_valid             : i_valid delayed by two cycles
// ---------------------------------------------------------------------------
module filter_kernel3x3
    import window_filter_pkg::*;
#(
    parameter int COLORDEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] i_col_l [2:0],
    input  logic [COLORDEPTH-1:0] i_col_m [2:0],
    input  logic [COLORDEPTH-1:0] i_col_r [2:0],
    input  mode_e                 i_mode,
    input  logic                  i_valid,
    output logic [COLORDEPTH-1:0] o_pix,
    output logic                  o_valid
);

    // 5 guard bits cover the Gaussian sum (16 * max) and negative sharpen results.
    localparam int W  = COLORDEPTH + 5;
    localparam int HI = (1 << COLORDEPTH) - 1;

    typedef logic signed [W-1:0] sw_t;

    function automatic sw_t ext(input logic [COLORDEPTH-1:0] p);
        return {5'b0, p};
    endfunction

    sw_t w_tl, w_tm, w_tr, w_ml, w_mm, w_mr, w_bl, w_bm, w_br;
    sw_t w_gauss, w_gx, w_gy, w_abs_gx, w_abs_gy, w_sharp;

    sw_t                   r_gauss;
    sw_t                   r_abs_gx;
    sw_t                   r_abs_gy;
    sw_t                   r_sharp;
    logic [COLORDEPTH-1:0] r_centre;
    mode_e                 r_mode;
    logic                  r_valid1;

    logic [COLORDEPTH-1:0] w_result;
    logic [COLORDEPTH-1:0] r_pix;
    logic                  r_valid2;

    always_comb begin
        w_tl = ext(i_col_l[2]);
        w_tm = ext(i_col_m[2]);
        w_tr = ext(i_col_r[2]);
        w_ml = ext(i_col_l[1]);
        w_mm = ext(i_col_m[1]);
        w_mr = ext(i_col_r[1]);
        w_bl = ext(i_col_l[0]);
        w_bm = ext(i_col_m[0]);
        w_br = ext(i_col_r[0]);

        w_gauss = w_tl + w_tr + w_bl + w_br
                + ((w_tm + w_ml + w_mr + w_bm) <<< 1)
                + (w_mm <<< 2);

        w_gx = (w_tr + (w_mr <<< 1) + w_br) - (w_tl + (w_ml <<< 1) + w_bl);
        w_gy = (w_bl + (w_bm <<< 1) + w_br) - (w_tl + (w_tm <<< 1) + w_tr);
        w_abs_gx = w_gx[W-1] ? -w_gx : w_gx;
        w_abs_gy = w_gy[W-1] ? -w_gy : w_gy;

        w_sharp = (w_mm <<< 2) + w_mm - w_tm - w_bm - w_ml - w_mr;
    end

    // Stage 1: every kernel's partial result is registered; mode travels along
    // so a window and its kernel choice always stay paired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gauss  <= '0;
            r_abs_gx <= '0;
            r_abs_gy <= '0;
            r_sharp  <= '0;
            r_centre <= '0;
            r_mode   <= MODE_BYPASS;
            r_valid1 <= 1'b0;
        end else begin
            r_gauss  <= w_gauss;
            r_abs_gx <= w_abs_gx;
            r_abs_gy <= w_abs_gy;
            r_sharp  <= w_sharp;
            r_centre <= i_col_m[1];
            r_mode   <= i_mode;
            r_valid1 <= i_valid;
        end
    end

    always_comb begin
        w_result = '0;
        case (r_mode)
            MODE_BYPASS:  w_result = r_centre;
            MODE_GAUSS:   w_result = COLORDEPTH'(r_gauss >>> 4);
            MODE_SOBEL:   w_result = COLORDEPTH'(clamp_range(int'(r_abs_gx + r_abs_gy), HI));
            MODE_SHARPEN: w_result = COLORDEPTH'(clamp_range(int'(r_sharp), HI));
            default:      w_result = '0;
        endcase
    end

    // Stage 2: final select/clamp; pixel is zeroed whenever no valid window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix    <= '0;
            r_valid2 <= 1'b0;
        end else begin
            r_pix    <= r_valid1 ? w_result : '0;
            r_valid2 <= r_valid1;
        end
    end

    assign o_pix   = r_pix;
    assign o_valid = r_valid2;

endmodule

// File: rtl/window_filter3x3.sv
// ---------------------------------------------------------------------------
// window_filter3x3
// Builds a 3x3 sliding window (edge-replicated) from the line buffer's
// column stream and filters it with a frame-selectable kernel.
//   clk, rst   : clock, synchronous active-high reset
//   mode_i     : kernel select, captured on the vs_i rising edge
//   col_i[2:0] : pixel column, [0] newest (bottom) .. [2] oldest (top)
//   dv_i       : column valid, one contiguous run per line
//   hs_i, vs_i : syncs aligned with col_i
//   pix_o      : filtered pixel, 0 when dv_o is low
//   dv_o/hs_o/vs_o : inputs delayed by LATENCY cycles
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no line in progress; next valid column seeds the window
// ACTIVE | line in progress; each column shifts, first low cycle flushes
// ---------------------------------------------------------------------------
module window_filter3x3 #(
    parameter int COLORDEPTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode_i,
    input  logic [COLORDEPTH-1:0] col_i [2:0],
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] pix_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    import window_filter_pkg::*;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_load_first;
    logic                  w_shift;
    logic                  w_win_v_nxt;

    logic [COLORDEPTH-1:0] r_c_l [2:0];
    logic [COLORDEPTH-1:0] r_c_m [2:0];
    logic [COLORDEPTH-1:0] r_c_r [2:0];
    logic                  r_win_v;

    mode_e                 r_mode_q;
    logic                  r_vs_prev;

    logic [LATENCY-1:0]    r_hs_dly;
    logic [LATENCY-1:0]    r_vs_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_first = 1'b0;
        w_shift      = 1'b0;
        w_win_v_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (dv_i) begin
                    w_load_first = 1'b1;
                    w_state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                // A low dv_i here is the flush cycle: shift once more with the
                // right column held, which replicates the right edge.
                w_shift     = 1'b1;
                w_win_v_nxt = 1'b1;
                if (!dv_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The first column lands in both middle and right so the next shift yields
    // (P0, P0, P1): the left edge replicated without a special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_l   <= '{default: '0};
            r_c_m   <= '{default: '0};
            r_c_r   <= '{default: '0};
            r_win_v <= 1'b0;
        end else begin
            r_win_v <= w_win_v_nxt;
            if (w_load_first) begin
                r_c_m <= col_i;
                r_c_r <= col_i;
            end else if (w_shift) begin
                r_c_l <= r_c_m;
                r_c_m <= r_c_r;
                if (dv_i) begin
                    r_c_r <= col_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q  <= MODE_BYPASS;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= vs_i;
            if (vs_i && !r_vs_prev) begin
                r_mode_q <= mode_e'(mode_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_dly <= '0;
            r_vs_dly <= '0;
        end else begin
            r_hs_dly <= {r_hs_dly[LATENCY-2:0], hs_i};
            r_vs_dly <= {r_vs_dly[LATENCY-2:0], vs_i};
        end
    end

    filter_kernel3x3 #(
        .COLORDEPTH (COLORDEPTH)
    ) u_kernel (
        .clk     (clk),
        .rst     (rst),
        .i_col_l (r_c_l),
        .i_col_m (r_c_m),
        .i_col_r (r_c_r),
        .i_mode  (r_mode_q),
        .i_valid (r_win_v),
        .o_pix   (pix_o),
        .o_valid (dv_o)
    );

    assign hs_o = r_hs_dly[LATENCY-1];
    assign vs_o = r_vs_dly[LATENCY-1];

endmodule

// File: tb/tb_window_filter3x3.sv
// ---------------------------------------------------------------------------
// tb_window_filter3x3
// Scoreboard bench: expected pixels are queued when a line is driven and
// popped whenever dv_o is high; dv/hs/vs outputs are compared against the
// inputs delayed by four cycles.
// ---------------------------------------------------------------------------
module tb_window_filter3x3;

    localparam int CD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_i;
    logic [CD-1:0] col_i [2:0];
    logic          dv_i, hs_i, vs_i;
    logic [CD-1:0] pix_o;
    logic          dv_o, hs_o, vs_o;

    always #5 clk = ~clk;

    window_filter3x3 #(
        .COLORDEPTH (CD),
        .LATENCY    (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_i),
        .col_i  (col_i),
        .dv_i   (dv_i),
        .hs_i   (hs_i),
        .vs_i   (vs_i),
        .pix_o  (pix_o),
        .dv_o   (dv_o),
        .hs_o   (hs_o),
        .vs_o   (vs_o)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_q[$];
    logic [3:0] dv_hist = '0;
    logic [3:0] hs_hist = '0;
    logic [3:0] vs_hist = '0;
    bit         mon_en = 1'b0;
    int         lp[64][3];
    int         ln;
    int         model_mode = 0;
    logic       vs_prev_m = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int px(input int x, input int r);
        int xc;
        xc = (x < 0) ? 0 : ((x >= ln) ? ln - 1 : x);
        return lp[xc][r];
    endfunction

    function automatic int kern(input int m, input int x);
        int tl, tm, tr, ml, mm, mr, bl, bm, br, gx, gy, s;
        tl = px(x-1, 2); tm = px(x, 2); tr = px(x+1, 2);
        ml = px(x-1, 1); mm = px(x, 1); mr = px(x+1, 1);
        bl = px(x-1, 0); bm = px(x, 0); br = px(x+1, 0);
        case (m)
            1: s = (tl + 2*tm + tr + 2*ml + 4*mm + 2*mr + bl + 2*bm + br) / 16;
            2: begin
                gx = (tr + 2*mr + br) - (tl + 2*ml + bl);
                gy = (bl + 2*bm + br) - (tl + 2*tm + tr);
                s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (s > 255) s = 255;
            end
            3: begin
                s = 5*mm - tm - bm - ml - mr;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
            end
            default: s = mm;
        endcase
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            dv_hist <= '0;
            hs_hist <= '0;
            vs_hist <= '0;
            exp_q.delete();
        end else begin
            dv_hist <= {dv_hist[2:0], dv_i};
            hs_hist <= {hs_hist[2:0], hs_i};
            vs_hist <= {vs_hist[2:0], vs_i};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("dv_o", int'(dv_o), int'(dv_hist[3]));
            check("hs_o", int'(hs_o), int'(hs_hist[3]));
            check("vs_o", int'(vs_o), int'(vs_hist[3]));
            if (dv_o) begin
                if (exp_q.size() == 0) check("pix_extra", exp_q.size(), 1);
                else                   check("pix_o", int'(pix_o), exp_q.pop_front());
            end else begin
                check("pix_idle", int'(pix_o), 0);
            end
        end
    end

    task automatic step(input logic dv, input logic hs, input logic vs,
                        input int c0, input int c1, input int c2);
        dv_i = dv; hs_i = hs; vs_i = vs;
        col_i[0] = CD'(c0); col_i[1] = CD'(c1); col_i[2] = CD'(c2);
        if (!rst) begin
            if (vs && !vs_prev_m) model_mode = int'(mode_i);
            vs_prev_m = vs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic vs_pulse(input int m);
        mode_i = 2'(m);
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(2);
    endtask

    // Drives lp[0..n-1] as one line, queues its expected pixels, one gap cycle.
    task automatic run_line(input int n);
        ln = n;
        for (int x = 0; x < n; x++) exp_q.push_back(kern(model_mode, x));
        for (int x = 0; x < n; x++) step(1'b1, (x == 0), 1'b0, lp[x][0], lp[x][1], lp[x][2]);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic fill_const(input int n, input int v);
        for (int x = 0; x < n; x++) for (int r = 0; r < 3; r++) lp[x][r] = v;
    endtask

    task automatic fill_rand(input int n);
        for (int x = 0; x < n; x++) for (int r = 0; r < 3; r++) lp[x][r] = int'($urandom_range(0, 255));
    endtask

    initial begin
        rst = 1'b1; mode_i = 2'd0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        col_i[0] = '0; col_i[1] = '0; col_i[2] = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // reset held with random inputs
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        rst = 1'b0; model_mode = 0; vs_prev_m = 1'b0; mode_i = 2'd0;
        idle(3);

        // bypass ramp 10..17
        vs_pulse(0);
        for (int x = 0; x < 8; x++) for (int r = 0; r < 3; r++) lp[x][r] = 10 + x;
        run_line(8);
        idle(3);

        // Gaussian on flat 100
        vs_pulse(1);
        fill_const(16, 100);
        run_line(16);
        idle(3);

        // Sobel vertical edge
        vs_pulse(2);
        for (int x = 0; x < 8; x++) for (int r = 0; r < 3; r++) lp[x][r] = (x < 4) ? 0 : 200;
        run_line(8);
        idle(3);

        // sharpen centre spike
        vs_pulse(3);
        fill_const(5, 50);
        lp[2][1] = 60;
        run_line(5);
        idle(3);

        // random lines through every kernel
        for (int m = 0; m < 4; m++) begin
            vs_pulse(m);
            fill_rand(12);
            run_line(12);
            idle(2);
        end

        // mode change mid-frame takes effect only at next vs rise
        vs_pulse(0);
        fill_rand(7);
        run_line(7);
        mode_i = 2'd1;
        idle(2);
        fill_rand(7);
        run_line(7);
        idle(2);
        vs_pulse(1);
        fill_rand(7);
        run_line(7);
        idle(3);

        // 1-column line
        lp[0][0] = 33; lp[0][1] = 77; lp[0][2] = 120;
        run_line(1);
        idle(3);

        // back-to-back lines, single gap cycle
        fill_rand(6);
        run_line(6);
        fill_rand(5);
        run_line(5);
        idle(3);

        // reset in the middle of a line
        fill_rand(10);
        ln = 10;
        for (int x = 0; x < 10; x++) exp_q.push_back(kern(model_mode, x));
        for (int x = 0; x < 5; x++) step(1'b1, (x == 0), 1'b0, lp[x][0], lp[x][1], lp[x][2]);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, lp[5][0], lp[5][1], lp[5][2]);
        step(1'b1, 1'b0, 1'b0, lp[6][0], lp[6][1], lp[6][2]);
        rst = 1'b0; model_mode = 0; vs_prev_m = 1'b0;
        idle(8);

        // recovery after reset
        vs_pulse(2);
        fill_rand(4);
        run_line(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("queue_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
